// File: rtl/stack_op_sequencer.sv
// stack_op_sequencer: bounds-checked push/pop/set sequencer driving a single-port memory for a base+offset stack
module stack_op_sequencer #(
  parameter int STACK_LO = 32,
  parameter int STACK_HI = 40,
  parameter int RESET_SPBA = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] sp_out,
  output logic [31:0] spba_out,
  output logic        overflow,
  output logic        underflow,
  input  logic        err_clr
);
  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;
  localparam logic [32:0] lo = 33'(STACK_LO);
  localparam logic [32:0] hi = 33'(STACK_HI);
  state_t state, state_nx;
  logic [31:0] sp, spba, wdata, rdata;
  logic push, err, acc, push_err, pop_err, set_err, bad;
  logic [32:0] a, sum_sp, sum_spba;
  assign a = {1'b0, spba} + {sp[31], sp};
  assign sum_sp = {1'b0, spba} + {cmd_data[31], cmd_data};
  assign sum_spba = {1'b0, cmd_data} + {sp[31], sp};
  assign acc = cmd_valid && state == IDLE;
  assign push_err = a <= lo;
  assign pop_err = a >= hi;
  assign set_err = cmd_op[0] ? (sum_spba < lo || sum_spba > hi) : (sum_sp < lo || sum_sp > hi);
  assign bad = cmd_op[1] ? set_err : cmd_op[0] ? pop_err : push_err;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (acc ? ((cmd_op[1] || bad) ? DONE : MEM) : IDLE)
             : state == MEM ? (mem_ack ? DONE : MEM)
             : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sp <= '0;
      spba <= 32'(RESET_SPBA);
      overflow <= 1'b0;
      underflow <= 1'b0;
      push <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      err <= 1'b0;
    end else begin
      state <= state_nx;
      overflow <= (acc && cmd_op == 2'b00 && push_err) || (overflow && !err_clr);
      underflow <= (acc && cmd_op == 2'b01 && pop_err) || (underflow && !err_clr);
      if (acc) begin
        push <= !cmd_op[0];
        wdata <= cmd_data;
        rdata <= '0;
        err <= bad;
        if (cmd_op == 2'b10 && !bad) sp <= cmd_data;
        if (cmd_op == 2'b11 && !bad) spba <= cmd_data;
      end
      if (state == MEM && mem_ack) begin
        sp <= push ? sp - 32'd1 : sp + 32'd1;
        if (!push) rdata <= mem_rdata;
      end
    end
  end
  assign cmd_ready = state == IDLE;
  assign mem_req = state == MEM;
  assign mem_we = mem_req && push;
  assign mem_addr = mem_req ? (push ? a[31:0] - 32'd1 : a[31:0]) : '0;
  assign mem_wdata = mem_we ? wdata : '0;
  assign rsp_valid = state == DONE;
  assign rsp_data = rsp_valid ? rdata : '0;
  assign rsp_err = rsp_valid && err;
  assign sp_out = sp;
  assign spba_out = spba;
endmodule

// File: tb/tb_stack_op_sequencer.sv
// tb_stack_op_sequencer: directed self-checking bench for stack_op_sequencer
module tb_stack_op_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [31:0] cmd_data = '0;
  logic mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic rsp_valid, rsp_err, overflow, underflow;
  logic [31:0] rsp_data, sp_out, spba_out;
  logic err_clr = 1'b0;
  logic [31:0] mem [0:63];
  int checks = 0;
  int passed = 0;
  stack_op_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .sp_out(sp_out), .spba_out(spba_out),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] d);
    cmd_op = op;
    cmd_data = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic mem_op(input logic [1:0] op, input logic [31:0] d, input int dly,
                        input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    issue(op, d);
    chk("mem_req", 32'(mem_req), 32'd1);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_we", 32'(mem_we), 32'(op == 2'b00));
    chk("mem_wdata", mem_wdata, op == 2'b00 ? d : 32'd0);
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("hold_req", 32'(mem_req), 32'd1);
      chk("hold_addr", mem_addr, exp_addr);
      chk("hold_rsp", 32'(rsp_valid), 32'd0);
    end
    mem_rdata = mem[mem_addr[5:0]];
    if (mem_we) mem[mem_addr[5:0]] = mem_wdata;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'd0);
    chk("rsp_data", rsp_data, exp_rdata);
    chk("mem_req_off", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_sp", sp_out, 32'd0);
    chk("rst_spba", spba_out, 32'd40);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    mem_op(2'b00, 32'hA5A5_0001, 0, 32'd39, 32'd0);
    chk("sp_after_push", sp_out, 32'hFFFF_FFFF);
    for (int i = 1; i < 8; i++) mem_op(2'b00, 32'h100 + 32'(i), 0, 32'(39 - i), 32'd0);
    chk("sp_full", sp_out, 32'hFFFF_FFF8);
    issue(2'b00, 32'h5555);
    chk("ovf_rsp", 32'(rsp_valid), 32'd1);
    chk("ovf_err", 32'(rsp_err), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_noreq", 32'(mem_req), 32'd0);
    chk("ovf_sp", sp_out, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("idle_err_zero", 32'(rsp_err), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack", sp_out, 32'hFFFF_FFF8);
    for (int j = 0; j < 8; j++)
      mem_op(2'b01, 32'd0, 0, 32'(32 + j), j == 7 ? 32'hA5A5_0001 : 32'h100 + 32'(7 - j));
    chk("sp_empty", sp_out, 32'd0);
    issue(2'b01, 32'd0);
    chk("unf_rsp", 32'(rsp_valid), 32'd1);
    chk("unf_err", 32'(rsp_err), 32'd1);
    chk("unf_flag", 32'(underflow), 32'd1);
    chk("unf_noreq", 32'(mem_req), 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    chk("unf_clr", 32'(underflow), 32'd0);
    issue(2'b01, 32'd0);
    chk("set_wins", 32'(underflow), 32'd1);
    @(negedge clk);
    err_clr = 1'b0;
    chk("clr_after", 32'(underflow), 32'd0);
    mem_op(2'b00, 32'h1234, 0, 32'd39, 32'd0);
    mem_op(2'b01, 32'd0, 5, 32'd39, 32'h1234);
    chk("sp_back", sp_out, 32'd0);
    issue(2'b11, 32'h20);
    chk("spba_rsp", 32'(rsp_valid), 32'd1);
    chk("spba_ok", 32'(rsp_err), 32'd0);
    chk("spba_val", spba_out, 32'd32);
    @(negedge clk);
    issue(2'b10, 32'd9);
    chk("sp9_err", 32'(rsp_err), 32'd1);
    chk("sp9_keep", sp_out, 32'd0);
    chk("sp9_flags", {30'd0, overflow, underflow}, 32'd0);
    @(negedge clk);
    issue(2'b10, 32'd8);
    chk("sp8_ok", 32'(rsp_err), 32'd0);
    chk("sp8_val", sp_out, 32'd8);
    @(negedge clk);
    issue(2'b11, 32'd40);
    chk("spba48_err", 32'(rsp_err), 32'd1);
    chk("spba48_keep", spba_out, 32'd32);
    @(negedge clk);
    issue(2'b10, 32'd0);
    @(negedge clk);
    issue(2'b11, 32'd40);
    chk("restore_spba", spba_out, 32'd40);
    chk("restore_sp", sp_out, 32'd0);
    @(negedge clk);
    issue(2'b00, 32'hDEAD);
    chk("rst_mem_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abandon_req", 32'(mem_req), 32'd0);
    chk("abandon_rsp", 32'(rsp_valid), 32'd0);
    chk("abandon_sp", sp_out, 32'd0);
    chk("abandon_spba", spba_out, 32'd40);
    @(negedge clk);
    chk("abandon_rsp2", 32'(rsp_valid), 32'd0);
    mem_op(2'b00, 32'hBEEF, 0, 32'd39, 32'd0);
    chk("post_rst_sp", sp_out, 32'hFFFF_FFFF);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
